// File: rtl/fighter_meter.sv
// Health and special-meter tracker for one fighter, advanced once per frame tick.
// Optional passive meter regeneration is enabled by defining METER_REGEN_EN.
module fighter_meter #(
    parameter int MAX_HP    = 200,
    parameter int PUNCH_DMG = 10,
    parameter int BLOCK_DMG = 2,
    parameter int SPESH_DMG = 40,
    parameter int IFRAMES   = 8,
    parameter int METER_HIT = 10,
    parameter int METER_DIV = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       opp_hit,
    input  logic       opp_spesh,
    input  logic       blocking,
    input  logic       own_hit,
    input  logic       spesh_start,
    input  logic       round_start,
    output logic [9:0] health,
    output logic [9:0] BS,
    output logic       isdead,
    output logic       ko,
    output logic       invuln,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        FIGHT  = 2'd0,
        IFRAME = 2'd1,
        DEAD   = 2'd2
    } state_t;

    localparam logic [9:0]  HP_INIT  = 10'(MAX_HP);
    localparam logic [10:0] BS_MAX   = 11'd200;
    localparam logic [10:0] PUNCH_W  = 11'(PUNCH_DMG);
    localparam logic [10:0] BLOCK_W  = 11'(BLOCK_DMG);
    localparam logic [10:0] SPESH_W  = 11'(SPESH_DMG);
    localparam logic [10:0] HIT_GAIN = 11'(METER_HIT);
    localparam logic [7:0]  IFR_LOAD = 8'(IFRAMES);

    state_t      state_q, state_d;
    logic        frame_clk_q, frame_clk_d;
    logic        seen_low_q, seen_low_d;
    logic        tick_q, tick_d;
    logic [9:0]  health_q, health_d;
    logic [9:0]  bs_q, bs_d;
    logic [7:0]  ifr_cnt_q, ifr_cnt_d;
    logic        ko_q, ko_d;

    logic [10:0] dmg;
    logic [10:0] hp_diff;
    logic [10:0] gain;
    logic [10:0] bs_sum;

`ifdef METER_REGEN_EN
    localparam logic [7:0] DIV_LAST = 8'(METER_DIV - 1);
    logic [7:0] div_cnt_q, div_cnt_d;
`endif

    // A tick needs frame_clk seen low since reset, so a release mid-frame
    // cannot fake a rising edge.
    always_comb begin
        frame_clk_d = frame_clk;
        seen_low_d  = seen_low_q | ~frame_clk;
        tick_d      = frame_clk & ~frame_clk_q & seen_low_q;
    end

    always_comb begin
        state_d   = state_q;
        health_d  = health_q;
        bs_d      = bs_q;
        ifr_cnt_d = ifr_cnt_q;
        ko_d      = 1'b0;
        dmg       = 11'd0;
        hp_diff   = 11'd0;
        gain      = 11'd0;
        bs_sum    = 11'd0;
`ifdef METER_REGEN_EN
        div_cnt_d = div_cnt_q;
`endif
        if (tick_q) begin
            if (round_start) begin
                state_d   = FIGHT;
                health_d  = HP_INIT;
                bs_d      = 10'd0;
                ifr_cnt_d = 8'd0;
`ifdef METER_REGEN_EN
                div_cnt_d = 8'd0;
`endif
            end else if (state_q != DEAD) begin
                gain = own_hit ? HIT_GAIN : 11'd0;
`ifdef METER_REGEN_EN
                if (div_cnt_q >= DIV_LAST) begin
                    div_cnt_d = 8'd0;
                    gain      = gain + 11'd1;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
`endif
                bs_sum = {1'b0, bs_q} + gain;
                if (spesh_start) begin
                    bs_d = 10'd0;
                end else if (bs_sum > BS_MAX) begin
                    bs_d = BS_MAX[9:0];
                end else begin
                    bs_d = bs_sum[9:0];
                end

                if (state_q == IFRAME) begin
                    if (ifr_cnt_q <= 8'd1) begin
                        ifr_cnt_d = 8'd0;
                        state_d   = FIGHT;
                    end else begin
                        ifr_cnt_d = ifr_cnt_q - 8'd1;
                    end
                end else begin
                    if (opp_spesh) begin
                        dmg = SPESH_W;
                    end else if (opp_hit) begin
                        dmg = blocking ? BLOCK_W : PUNCH_W;
                    end
                    hp_diff = {1'b0, health_q} - dmg;
                    // Sign bit of the 11-bit difference flags an underflow.
                    if (dmg != 11'd0) begin
                        if (hp_diff[10] || hp_diff == 11'd0) begin
                            health_d  = 10'd0;
                            state_d   = DEAD;
                            ko_d      = 1'b1;
                            ifr_cnt_d = 8'd0;
                        end else begin
                            health_d  = hp_diff[9:0];
                            state_d   = IFRAME;
                            ifr_cnt_d = IFR_LOAD;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_clk_q <= 1'b0;
            seen_low_q  <= 1'b0;
            tick_q      <= 1'b0;
            state_q     <= FIGHT;
            health_q    <= HP_INIT;
            bs_q        <= 10'd0;
            ifr_cnt_q   <= 8'd0;
            ko_q        <= 1'b0;
`ifdef METER_REGEN_EN
            div_cnt_q   <= 8'd0;
`endif
        end else begin
            frame_clk_q <= frame_clk_d;
            seen_low_q  <= seen_low_d;
            tick_q      <= tick_d;
            state_q     <= state_d;
            health_q    <= health_d;
            bs_q        <= bs_d;
            ifr_cnt_q   <= ifr_cnt_d;
            ko_q        <= ko_d;
`ifdef METER_REGEN_EN
            div_cnt_q   <= div_cnt_d;
`endif
        end
    end

    assign health    = health_q;
    assign BS        = bs_q;
    assign isdead    = (state_q == DEAD);
    assign invuln    = (state_q == IFRAME);
    assign ko        = ko_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fighter_meter.sv
// Bench for fighter_meter: directed scenarios plus random ticks against a
// per-tick behavioural model of health, meter and invulnerability.
module tb_fighter_meter;

    localparam int MAX_HP    = 200;
    localparam int PUNCH_DMG = 10;
    localparam int BLOCK_DMG = 2;
    localparam int SPESH_DMG = 40;
    localparam int IFRAMES   = 8;
    localparam int METER_HIT = 10;
    localparam int METER_DIV = 4;
    localparam int BS_CAP    = 200;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       opp_hit = 1'b0;
    logic       opp_spesh = 1'b0;
    logic       blocking = 1'b0;
    logic       own_hit = 1'b0;
    logic       spesh_start = 1'b0;
    logic       round_start = 1'b0;
    logic [9:0] health;
    logic [9:0] BS;
    logic       isdead;
    logic       ko;
    logic       invuln;
    logic [1:0] state_dbg;

    int errors = 0;
    int checks = 0;
    int ko_cnt = 0;

    int m_hp;
    int m_bs;
    int m_inv;
    int m_div;
    bit m_dead;
    bit m_died;

    logic [7:0] exp_q[$];

    fighter_meter dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .opp_hit    (opp_hit),
        .opp_spesh  (opp_spesh),
        .blocking   (blocking),
        .own_hit    (own_hit),
        .spesh_start(spesh_start),
        .round_start(round_start),
        .health     (health),
        .BS         (BS),
        .isdead     (isdead),
        .ko         (ko),
        .invuln     (invuln),
        .state_dbg  (state_dbg)
    );

    // clock / watchdog
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (errors=%0d checks=%0d)", errors, checks);
        $fatal(1);
    end

    // reference model: one call per frame tick
    task automatic model_reset();
        m_hp   = MAX_HP;
        m_bs   = 0;
        m_inv  = 0;
        m_div  = 0;
        m_dead = 0;
        m_died = 0;
    endtask

    task automatic model_step(input bit hit, input bit spesh, input bit blk,
                              input bit own, input bit sp, input bit rs);
        int gain;
        int dmg;
        m_died = 0;
        if (rs) begin
            model_reset();
        end else if (!m_dead) begin
            gain = own ? METER_HIT : 0;
`ifdef METER_REGEN_EN
            m_div++;
            if (m_div == METER_DIV) begin
                m_div = 0;
                gain++;
            end
`endif
            if (sp) m_bs = 0;
            else    m_bs = (m_bs + gain > BS_CAP) ? BS_CAP : m_bs + gain;
            if (m_inv > 0) begin
                m_inv--;
            end else begin
                dmg = spesh ? SPESH_DMG : (hit ? (blk ? BLOCK_DMG : PUNCH_DMG) : 0);
                if (dmg > 0) begin
                    if (dmg >= m_hp) begin
                        m_hp   = 0;
                        m_dead = 1;
                        m_died = 1;
                        m_inv  = 0;
                    end else begin
                        m_hp  = m_hp - dmg;
                        m_inv = IFRAMES;
                    end
                end
            end
        end
    endtask

    // drivers
    task automatic apply_reset();
        Reset_n     = 1'b0;
        frame_clk   = 1'b0;
        opp_hit     = 1'b0;
        opp_spesh   = 1'b0;
        blocking    = 1'b0;
        own_hit     = 1'b0;
        spesh_start = 1'b0;
        round_start = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        model_reset();
    endtask

    task automatic do_tick(input bit hit, input bit spesh, input bit blk,
                           input bit own, input bit sp, input bit rs, input bit noise);
        opp_hit     = hit;
        opp_spesh   = spesh;
        blocking    = blk;
        own_hit     = own;
        spesh_start = sp;
        round_start = rs;
        frame_clk   = 1'b1;
        ko_cnt      = 0;
        repeat (4) begin
            @(negedge Clk);
            if (ko === 1'b1) ko_cnt++;
        end
        frame_clk = 1'b0;
        if (noise) begin
            opp_hit     = 1'($urandom_range(0, 1));
            opp_spesh   = 1'($urandom_range(0, 1));
            blocking    = 1'($urandom_range(0, 1));
            own_hit     = 1'($urandom_range(0, 1));
            spesh_start = 1'($urandom_range(0, 1));
            round_start = 1'($urandom_range(0, 1));
        end
        repeat (4) begin
            @(negedge Clk);
            if (ko === 1'b1) ko_cnt++;
        end
        model_step(hit, spesh, blk, own, sp, rs);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(0, 0, 0, 0, 0, 0, 0);
    endtask

    // scenarios
    task automatic test_reset();
        apply_reset();
        checks++; if (health !== 10'd200) begin errors++; $display("FAIL reset_health: got %0d want 200", health); end
        checks++; if (BS !== 10'd0) begin errors++; $display("FAIL reset_bs: got %0d want 0", BS); end
        checks++; if ({isdead, ko, invuln} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {isdead, ko, invuln}); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    endtask

    task automatic test_single_hit();
        int inv_ticks;
        apply_reset();
        do_tick(1, 0, 0, 0, 0, 0, 0);
        checks++; if (health !== 10'd190) begin errors++; $display("FAIL single_hit_health: got %0d want 190", health); end
        inv_ticks = (invuln === 1'b1) ? 1 : 0;
        for (int i = 0; i < 12; i++) begin
            do_tick(0, 0, 0, 0, 0, 0, 0);
            if (invuln === 1'b1) inv_ticks++;
        end
        checks++; if (inv_ticks != IFRAMES) begin errors++; $display("FAIL single_hit_iframes: got %0d want %0d", inv_ticks, IFRAMES); end
        checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL single_hit_invuln_end: got %b want 0", invuln); end
    endtask

    task automatic test_block_hold();
        int prev;
        apply_reset();
        exp_q = {8'd1, 8'd10, 8'd19};
        for (int t = 1; t <= 20; t++) begin
            prev = int'(health);
            do_tick(1, 0, 1, 0, 0, 0, 0);
            if (int'(health) != prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL block_drop_extra: tick %0d health %0d", t, health);
                end else begin
                    if (8'(t) !== exp_q[0] || prev - int'(health) != BLOCK_DMG) begin
                        errors++; $display("FAIL block_drop: tick %0d drop %0d want tick %0d drop %0d", t, prev - int'(health), exp_q[0], BLOCK_DMG);
                    end
                    void'(exp_q.pop_front());
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL block_drops_missing: got %0d left want 0", exp_q.size()); end
        checks++; if (health !== 10'd194) begin errors++; $display("FAIL block_health: got %0d want 194", health); end
    endtask

    task automatic test_ko();
        logic [9:0] bs_before;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            do_tick(0, 1, 0, 0, 0, 0, 0);
            idle_ticks(IFRAMES);
        end
        do_tick(1, 0, 0, 1, 0, 0, 0);
        idle_ticks(IFRAMES);
        checks++; if (health !== 10'd30) begin errors++; $display("FAIL ko_setup_health: got %0d want 30", health); end
        do_tick(1, 1, 0, 0, 0, 0, 0);
        checks++; if (health !== 10'd0) begin errors++; $display("FAIL ko_health: got %0d want 0", health); end
        checks++; if (isdead !== 1'b1 || state_dbg !== 2'd2) begin errors++; $display("FAIL ko_dead: got isdead=%b state=%0d want 1/2", isdead, state_dbg); end
        checks++; if (ko_cnt != 1) begin errors++; $display("FAIL ko_pulse: got %0d cycles want 1", ko_cnt); end
        bs_before = BS;
        for (int i = 0; i < 3; i++) do_tick(1, 1, 0, 1, 0, 0, 0);
        checks++; if (health !== 10'd0 || isdead !== 1'b1 || invuln !== 1'b0) begin errors++; $display("FAIL ko_frozen: got hp=%0d dead=%b inv=%b want 0/1/0", health, isdead, invuln); end
        checks++; if (BS !== bs_before || ko_cnt != 0) begin errors++; $display("FAIL ko_bs_frozen: got bs=%0d ko=%0d want %0d/0", BS, ko_cnt, bs_before); end
    endtask

    task automatic test_round_start();
        do_tick(0, 1, 0, 1, 0, 1, 0);
        checks++; if (health !== 10'd200 || BS !== 10'd0) begin errors++; $display("FAIL round_start_vals: got hp=%0d bs=%0d want 200/0", health, BS); end
        checks++; if (isdead !== 1'b0 || invuln !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL round_start_state: got dead=%b inv=%b state=%0d want 0/0/0", isdead, invuln, state_dbg); end
    endtask

    task automatic test_meter();
        apply_reset();
        for (int i = 0; i < 21; i++) begin
            do_tick(0, 0, 0, 1, 0, 0, 0);
            idle_ticks(9);
        end
        checks++; if (int'(BS) != m_bs) begin errors++; $display("FAIL meter_model: got %0d want %0d", BS, m_bs); end
`ifndef METER_REGEN_EN
        checks++; if (BS !== 10'd200) begin errors++; $display("FAIL meter_saturate: got %0d want 200", BS); end
`endif
        do_tick(0, 0, 0, 1, 1, 0, 0);
        checks++; if (BS !== 10'd0) begin errors++; $display("FAIL meter_spesh_clear: got %0d want 0", BS); end
    endtask

`ifdef METER_REGEN_EN
    task automatic test_regen();
        apply_reset();
        idle_ticks(40);
        checks++; if (BS !== 10'd10) begin errors++; $display("FAIL regen_40: got %0d want 10", BS); end
    endtask
`endif

    task automatic test_async_reset();
        apply_reset();
        do_tick(0, 0, 0, 1, 0, 0, 0);
        do_tick(1, 0, 0, 0, 0, 0, 0);
        checks++; if (invuln !== 1'b1 || BS === 10'd0) begin errors++; $display("FAIL async_setup: got inv=%b bs=%0d want 1/nonzero", invuln, BS); end
        #2 Reset_n = 1'b0;
        #1;
        checks++; if (health !== 10'd200 || BS !== 10'd0) begin errors++; $display("FAIL async_vals: got hp=%0d bs=%0d want 200/0", health, BS); end
        checks++; if ({isdead, ko, invuln} !== 3'b000 || state_dbg !== 2'd0) begin errors++; $display("FAIL async_flags: got %b state=%0d want 000/0", {isdead, ko, invuln}, state_dbg); end
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        model_reset();
    endtask

    task automatic test_reset_mid_frame();
        Reset_n   = 1'b0;
        frame_clk = 1'b1;
        opp_hit   = 1'b1;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (6) @(negedge Clk);
        checks++; if (health !== 10'd200 || invuln !== 1'b0) begin errors++; $display("FAIL mid_frame_no_tick: got hp=%0d inv=%b want 200/0", health, invuln); end
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        model_reset();
        do_tick(1, 0, 0, 0, 0, 0, 0);
        checks++; if (health !== 10'd190) begin errors++; $display("FAIL mid_frame_first_tick: got %0d want 190", health); end
    endtask

    task automatic test_random();
        bit hit, spesh, blk, own, sp, rs;
        apply_reset();
        for (int t = 0; t < 300; t++) begin
            hit   = ($urandom_range(0, 99) < 35);
            spesh = ($urandom_range(0, 99) < 12);
            blk   = ($urandom_range(0, 99) < 50);
            own   = ($urandom_range(0, 99) < 30);
            sp    = ($urandom_range(0, 99) < 5);
            rs    = ($urandom_range(0, 99) < 3);
            do_tick(hit, spesh, blk, own, sp, rs, 1);
            checks++; if (int'(health) != m_hp) begin errors++; $display("FAIL rand_health t=%0d: got %0d want %0d", t, health, m_hp); end
            checks++; if (int'(BS) != m_bs) begin errors++; $display("FAIL rand_bs t=%0d: got %0d want %0d", t, BS, m_bs); end
            checks++; if (isdead !== m_dead) begin errors++; $display("FAIL rand_isdead t=%0d: got %b want %b", t, isdead, m_dead); end
            checks++; if (invuln !== (m_inv > 0)) begin errors++; $display("FAIL rand_invuln t=%0d: got %b want %b", t, invuln, (m_inv > 0)); end
            checks++; if (ko_cnt != int'(m_died)) begin errors++; $display("FAIL rand_ko t=%0d: got %0d want %0d", t, ko_cnt, m_died); end
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_block_hold();
        test_ko();
        test_round_start();
        test_meter();
`ifdef METER_REGEN_EN
        test_regen();
`endif
        test_async_reset();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fighter_meter.md
FIGHTER_METER -- requirements
Module: fighter_meter

Interface
REQ-001 Parameter MAX_HP, default 200: starting and maximum health.
REQ-002 Parameter PUNCH_DMG, default 10: damage per unblocked normal hit.
REQ-003 Parameter BLOCK_DMG, default 2: damage per normal hit taken while blocking.
REQ-004 Parameter SPESH_DMG, default 40: damage per special hit; blocking does not reduce it.
REQ-005 Parameter IFRAMES, default 8: frame ticks of invulnerability after taking damage.
REQ-006 Parameter METER_HIT, default 10: meter gain per landed own hit.
REQ-007 Parameter METER_DIV, default 4: frame ticks per +1 passive meter gain.
REQ-008 Clk  in  1  system clock; all state changes on its rising edge.
REQ-009 Reset_n  in  1  asynchronous, active-low reset.
REQ-010 frame_clk  in  1  vertical-sync frame clock, asynchronous to nothing; sampled on Clk.
REQ-011 opp_hit  in  1  opponent normal hit connects (opponent's hit output), level.
REQ-012 opp_spesh  in  1  opponent special projectile connects, level.
REQ-013 blocking  in  1  own fighter is in a crouch/block state.
REQ-014 own_hit  in  1  own fighter's hit output, level.
REQ-015 spesh_start  in  1  own fighter enters the special (consumes meter).
REQ-016 round_start  in  1  restart round, level.
REQ-017 health  out  10  current health, 0..MAX_HP.
REQ-018 BS  out  10  special meter, 0..200; 200 = special available.
REQ-019 isdead  out  1  high while health is 0.
REQ-020 ko  out  1  one-Clk pulse on entry to DEAD.
REQ-021 invuln  out  1  high during the invulnerability window.

Function
REQ-022 Tick: frame_clk registered once, then tick flag registered as (frame_clk & ~frame_clk_q); all updates occur only on the Clk edge where the tick flag is high; outputs change on that edge.
REQ-023 Inputs are sampled only on tick edges; level between ticks is ignored.
REQ-024 States FIGHT, IFRAME, DEAD; reset enters FIGHT.
REQ-025 FIGHT: opp_spesh -> health -= SPESH_DMG; else opp_hit -> health -= (blocking ? BLOCK_DMG : PUNCH_DMG); any damage -> IFRAME with counter loaded with IFRAMES.
REQ-026 opp_spesh and opp_hit on the same tick: only SPESH_DMG is applied.
REQ-027 Subtraction saturates at 0; result 0 -> DEAD, isdead=1, ko pulses for one Clk, overriding IFRAME entry.
REQ-028 IFRAME: damage inputs ignored, invuln=1, counter decrements per tick; counter reaching 0 -> FIGHT on that tick (window exactly IFRAMES ticks).
REQ-029 DEAD: health and BS frozen, all inputs except round_start ignored.
REQ-030 round_start in any state: health=MAX_HP, BS=0, counters cleared, -> FIGHT; it wins over every same-tick event.
REQ-031 Meter (FIGHT and IFRAME only): own_hit -> BS += METER_HIT, saturating at 200.
REQ-032 spesh_start -> BS=0; it wins over own_hit and passive gain on the same tick.
REQ-033 All arithmetic is computed in 11 bits before clamping to the 10-bit outputs; no wrap-around.

Reset
REQ-034 Reset_n low asynchronously forces health=MAX_HP, BS=0, isdead=0, ko=0, invuln=0, state FIGHT, tick and edge flops 0, all counters 0.
REQ-035 Reset deassertion mid-frame: the first tick is recognised only after a full low-to-high frame_clk transition is sampled.

Configuration
REQ-036 Macro METER_REGEN_EN defined: in FIGHT/IFRAME the divider counter increments per tick; at METER_DIV it reloads 0 and BS += 1, saturating at 200.
REQ-037 Macro METER_REGEN_EN undefined: no divider logic; BS changes only by REQ-031, REQ-032, and REQ-030.

Verification
REQ-038 opp_hit, blocking=0 on one tick from reset -> health 190, invuln=1 for exactly 8 ticks.
REQ-039 opp_hit held 20 ticks, blocking=1 -> health drops by 2 at ticks 1, 10, 19 -> 194.
REQ-040 opp_spesh+opp_hit same tick at health 30 -> health 0, isdead=1, ko high for one Clk, further hits ignored.
REQ-041 own_hit 21 times at 10-tick spacing (regen off) -> BS 200 saturated; spesh_start with own_hit same tick -> BS 0.
REQ-042 METER_REGEN_EN defined, 40 idle ticks from reset -> BS 10; Reset_n pulsed mid-window -> all outputs at reset values immediately.
REQ-043 round_start with opp_spesh on the same tick in DEAD -> health 200, BS 0, isdead 0, state FIGHT.
